sc_io_ports: RTL

- Parametrised memory-mapped I/O unit sitting beside the data memory in the single-cycle computer.
- Replaces the fixed three-out/two-in port scheme with N_OUT registered output ports and N_IN synchronised input ports.
- Adds per-input change-detect flags, an interrupt mask and an irq line.
- The CPU reaches it through the same address/data/wmem bus as dmem; top level selects io_read_data when io_sel is high.

---
 rtl/sc_io_ports.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sc_io_ports.sv
// Memory-mapped I/O unit: N_OUT output registers, N_IN synchronised inputs with change flags, mask and irq.
// Optional macro IO_DEBOUNCE_EN adds a per-input stable-cycle debounce in front of in_reg.
module sc_io_ports #(
  parameter int          DATA_W    = 32,
  parameter int          N_OUT     = 3,
  parameter int          N_IN      = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0080,
  parameter int          DB_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [31:0]            addr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   wmem,
  input  logic [N_IN*DATA_W-1:0] in_port,
  output logic [N_OUT*DATA_W-1:0] out_port,
  output logic                   io_sel,
  output logic [DATA_W-1:0]      io_read_data,
  output logic                   irq
);

  logic [4:0]        off;
  logic              wr;
  logic              wr_chg;
  logic              wr_mask;
  logic [DATA_W-1:0] out_q [N_OUT];
  logic [DATA_W-1:0] s1_q  [N_IN];
  logic [DATA_W-1:0] s2_q  [N_IN];
  logic [DATA_W-1:0] in_q  [N_IN];
  logic [N_IN-1:0]   load;
  logic [N_IN-1:0]   set_chg;
  logic [N_IN-1:0]   chg_q, chg_d;
  logic [N_IN-1:0]   mask_q;
  logic              irq_q, irq_d;
  logic              unused_ok;

  assign io_sel  = (addr[31:7] == BASE_ADDR[31:7]);
  assign off     = addr[6:2];
  assign wr      = wmem & io_sel;
  assign wr_chg  = wr && (off == 5'd24);
  assign wr_mask = wr && (off == 5'd25);

  assign unused_ok = ^{addr[1:0], DB_CYCLES[0]};

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
          out_q[gi] <= '0;
        else if (wr && (off == 5'(gi)))
          out_q[gi] <= wdata;
      end
      assign out_port[gi*DATA_W +: DATA_W] = out_q[gi];
    end

    for (gi = 0; gi < N_IN; gi++) begin : g_in
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          s1_q[gi] <= '0;
          s2_q[gi] <= '0;
          in_q[gi] <= '0;
        end else begin
          s1_q[gi] <= in_port[gi*DATA_W +: DATA_W];
          s2_q[gi] <= s1_q[gi];
          if (load[gi])
            in_q[gi] <= s2_q[gi];
        end
      end

`ifdef IO_DEBOUNCE_EN
      localparam int CNT_W = $clog2(DB_CYCLES + 1);
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Counts edges since s2 last changed; cleared on the edge that changes s2.
      always_comb begin
        cnt_d = cnt_q;
        if (s1_q[gi] != s2_q[gi])
          cnt_d = '0;
        else if (cnt_q != CNT_W'(DB_CYCLES))
          cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
          cnt_q <= '0;
        else
          cnt_q <= cnt_d;
      end

      assign load[gi] = (cnt_q == CNT_W'(DB_CYCLES));
`else
      assign load[gi] = 1'b1;
`endif

      assign set_chg[gi] = load[gi] && (s2_q[gi] != in_q[gi]);
    end
  endgenerate

  // A new change on the same edge as its W1C keeps the flag set.
  assign chg_d = (chg_q & ~(wr_chg ? wdata[N_IN-1:0] : '0)) | set_chg;
  assign irq_d = |(chg_q & mask_q);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      chg_q  <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      chg_q <= chg_d;
      irq_q <= irq_d;
      if (wr_mask)
        mask_q <= wdata[N_IN-1:0];
    end
  end

  assign irq = irq_q;

  always_comb begin
    io_read_data = '0;
    if (io_sel) begin
      for (int i = 0; i < N_OUT; i++)
        if (off == 5'(i)) io_read_data = out_q[i];
      for (int j = 0; j < N_IN; j++)
        if (off == 5'(16 + j)) io_read_data = in_q[j];
      if (off == 5'd24) io_read_data[N_IN-1:0] = chg_q;
      if (off == 5'd25) io_read_data[N_IN-1:0] = mask_q;
    end
  end

endmodule
